// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (A - B - Bi) one bit per clock, LSB first,
// using one full-subtractor cell, operand shift registers and a borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             bo_reg;
  logic [CW-1:0]    cnt_reg;
  logic             d;
  logic             bout;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d    = a_reg[0] ^ b_reg[0] ^ borrow_reg;
    bout = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      bo_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg      <= A;
            b_reg      <= B;
            borrow_reg <= Bi;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end else begin
            state_reg  <= IDLE;
          end
        end
        RUN: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          borrow_reg <= bout;
          acc_reg    <= {d, acc_reg[WIDTH-1:1]};
          cnt_reg    <= cnt_reg + 1'b1;
          // Last bit: publish the assembled word and the MSB borrow together
          if (cnt_reg == CW'(WIDTH - 1)) begin
            diff_reg  <= {d, acc_reg[WIDTH-1:1]};
            bo_reg    <= bout;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign diff = diff_reg;
  assign Bo   = bo_reg;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing A - B - Bi, one bit per clock, LSB first. It uses a single full-subtractor cell plus shift registers and a borrow flop. It is the area-minimal inverse counterpart to the team's ripple-carry adder netlists. It feeds the datapath through a start/done handshake and holds its result until the next operation.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  reset; synchronous, active-low.
start  input  1  request a new operation; sampled only when busy=0.
A  input  WIDTH  minuend; captured on the accepting edge only.
B  input  WIDTH  subtrahend; captured on the accepting edge only.
Bi  input  1  borrow-in; captured on the accepting edge only.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when diff/Bo become valid.
diff  output  WIDTH  registered result (A - B - Bi) mod 2^WIDTH.
Bo  output  1  registered borrow-out; 1 when A < B + Bi (unsigned).

Behaviour:
- Reset: while rst_n=0 at a rising edge:
  - state=IDLE.
  - busy=0, done=0, diff=0, Bo=0.
  - Shift registers, bit counter and borrow flop all 0.
- States: IDLE, RUN, DONE. Encoding is free. busy=1 exactly in RUN.
- IDLE:
  - start=1 at edge k: capture A, B, Bi into the shift regs and borrow flop, clear bit counter, go to RUN.
  - start=0: stay in IDLE.
- RUN, one bit per edge (edges k+1 .. k+WIDTH):
  - a=areg[0], b=breg[0], bin=borrow flop.
  - d = a^b^bin.
  - bout = (~a&b) | (~(a^b)&bin).
  - d shifts into the result reg at the MSB end; areg and breg shift right; borrow flop <= bout; counter++.
  - At edge k+WIDTH (counter = WIDTH-1 before the edge): diff <= final assembled result, Bo <= final bout, done <= 1, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - start=1: accept as in IDLE (back-to-back operation), go to RUN, done falls at the next edge.
  - start=0: go to IDLE, done falls.
- Latency: done is high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- diff and Bo change only at the completing edge or at reset. They hold their value through IDLE and through subsequent RUN phases.
- start while busy=1: ignored. Operands are not re-captured and timing is not affected.
- A, B, Bi changing during RUN: no effect.
- Reset mid-RUN: the operation is aborted. Everything goes to reset values and no done pulse is issued.
- Arithmetic is unsigned modulo 2^WIDTH. Bo is the true borrow out of the MSB, not a signed overflow flag.

Test Plan:
1. WIDTH=2; A=3, B=1, Bi=0; start at edge 0 -> busy high from edge 1 through edge 2; done high after edge 2; diff=2, Bo=0.
2. WIDTH=2; A=1, B=2, Bi=0 -> diff=3 (wrap-around), Bo=1. Then A=0, B=0, Bi=1 -> diff=3, Bo=1.
3. WIDTH=8; A=8'h5A, B=8'hA5, Bi=0 -> diff=8'hB5, Bo=1 after 8 RUN cycles. Then A=8'hFF, B=8'h01 -> diff=8'hFE, Bo=0.
4. WIDTH=8; start held high for 12 cycles with the operands changed mid-RUN -> first result uses the operands captured at edge 0. A second operation is accepted in the DONE cycle, with done pulses exactly 9 cycles apart.
5. WIDTH=8; rst_n=0 at the 4th RUN edge -> busy=0, done=0, diff=0, Bo=0, no done pulse. A new start afterwards completes correctly.
6. Random regression, WIDTH=8 and 32, 10k operations -> {Bo,diff} equals the reference (A - B - Bi) computed mod 2^(WIDTH+1), with done latency always WIDTH+1.
